// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: drives PC load controls, runs a single-outstanding
// imem request/response handshake, resolves redirects and stalls.
module fetch_sequencer #(
    parameter int WIDTH      = 32,
    parameter int INSN_BYTES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pc_cur,
    output logic [WIDTH-1:0] pc_next,
    output logic             pc_update_n,
    input  logic             stall,
    input  logic             trap,
    input  logic [WIDTH-1:0] trap_vec,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp_taken,
    input  logic [WIDTH-1:0] jmp_target,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic             if_valid,
    output logic [31:0]      if_insn,
    output logic [WIDTH-1:0] if_pc,
    output logic             flush_ifid
);

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        RESP,
        HOLD,
        DRAIN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      hold_q;
    logic [31:0]      hold_d;
    logic             redir;
    logic [WIDTH-1:0] redir_pc;
    logic [WIDTH-1:0] pc_inc;

    assign pc_inc = pc_cur + WIDTH'(INSN_BYTES);

    // Redirects are ignored while reset is held so outputs stay at reset values
    always_comb begin
        redir    = reset_n & (trap | br_taken | jmp_taken);
        redir_pc = jmp_target;
        if (trap) begin
            redir_pc = trap_vec;
        end else if (br_taken) begin
            redir_pc = br_target;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= BOOT;
            hold_q <= '0;
        end else begin
            state  <= state_nxt;
            hold_q <= hold_d;
        end
    end

    always_comb begin
        state_nxt   = state;
        hold_d      = hold_q;
        pc_next     = pc_cur;
        pc_update_n = 1'b1;
        flush_ifid  = 1'b0;
        if_valid    = 1'b0;
        if_insn     = '0;
        if_pc       = pc_cur;
        imem_req    = 1'b0;
        imem_addr   = pc_cur;

        unique case (state)
            BOOT: begin
                state_nxt = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    state_nxt = redir ? DRAIN : RESP;
                end
            end
            RESP: begin
                if (imem_rvalid) begin
                    if (redir) begin
                        state_nxt = REQ;
                    end else begin
                        if_valid = 1'b1;
                        if_insn  = imem_rdata;
                        if (stall) begin
                            hold_d    = imem_rdata;
                            state_nxt = HOLD;
                        end else begin
                            pc_next     = pc_inc;
                            pc_update_n = 1'b0;
                            state_nxt   = REQ;
                        end
                    end
                end else if (redir) begin
                    state_nxt = DRAIN;
                end
            end
            HOLD: begin
                if (redir) begin
                    state_nxt = REQ;
                end else begin
                    if_valid = 1'b1;
                    if_insn  = hold_q;
                    if (!stall) begin
                        pc_next     = pc_inc;
                        pc_update_n = 1'b0;
                        state_nxt   = REQ;
                    end
                end
            end
            DRAIN: begin
                // The in-flight response belongs to the abandoned PC
                if (imem_rvalid) begin
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase

        if (redir) begin
            pc_next     = redir_pc;
            pc_update_n = 1'b0;
            flush_ifid  = 1'b1;
            if_valid    = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with a PC register and a
// variable-latency instruction memory model around the DUT.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        pc_update_n;
    logic        stall = 1'b0;
    logic        trap = 1'b0;
    logic [31:0] trap_vec = '0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        jmp_taken = 1'b0;
    logic [31:0] jmp_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_insn;
    logic [31:0] if_pc;
    logic        flush_ifid;

    logic        gnt_en = 1'b0;
    int          lat = 1;
    logic [31:0] rst_pc = '0;

    fetch_sequencer #(.WIDTH(32), .INSN_BYTES(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc_cur      (pc_cur),
        .pc_next     (pc_next),
        .pc_update_n (pc_update_n),
        .stall       (stall),
        .trap        (trap),
        .trap_vec    (trap_vec),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jmp_taken   (jmp_taken),
        .jmp_target  (jmp_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_insn     (if_insn),
        .if_pc       (if_pc),
        .flush_ifid  (flush_ifid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        if (a == 32'h10) return 32'h00500093;
        return a ^ 32'hA500_0000;
    endfunction

    // PC register
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pc_cur <= rst_pc;
        else if (!pc_update_n) pc_cur <= pc_next;
    end

    // Memory: grant when enabled, respond lat cycles after the grant
    assign imem_gnt = imem_req & gnt_en;
    logic        pend;
    int          cnt;
    logic [31:0] pdata;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend        <= 1'b0;
            cnt         <= 0;
            pdata       <= '0;
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            imem_rvalid <= 1'b0;
            if (imem_gnt) begin
                if (lat <= 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= insn_of(imem_addr);
                end else begin
                    pend  <= 1'b1;
                    cnt   <= lat - 1;
                    pdata <= insn_of(imem_addr);
                end
            end else if (pend) begin
                if (cnt <= 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= pdata;
                    pend        <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } del_t;

    logic [31:0] q_addr[$];
    logic [31:0] q_pcn[$];
    del_t        q_del[$];
    del_t        d_mon;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected event value %h, none required", name, act);
    endtask

    // Monitor: pops and compares whenever the DUT presents an event
    always @(negedge clk) begin
        if (reset_n) begin
            if (imem_req && imem_gnt) begin
                if (q_addr.size() == 0) unexpected("imem_addr", imem_addr);
                else chk("imem_addr", imem_addr, q_addr.pop_front());
            end
            if (!pc_update_n) begin
                if (q_pcn.size() == 0) unexpected("pc_next", pc_next);
                else chk("pc_next", pc_next, q_pcn.pop_front());
            end
            if (if_valid && !stall) begin
                if (q_del.size() == 0) begin
                    unexpected("if_pc", if_pc);
                end else begin
                    d_mon = q_del.pop_front();
                    chk("if_pc", if_pc, d_mon.pc);
                    chk("if_insn", if_insn, d_mon.insn);
                end
            end
            if (flush_ifid) chk1("flush_ifvalid", if_valid, 1'b0);
        end
    end

    function automatic void exp_fetch(input logic [31:0] a);
        q_addr.push_back(a);
        q_pcn.push_back(a + 32'd4);
        q_del.push_back('{pc: a, insn: insn_of(a)});
    endfunction

    task automatic do_reset(input logic [31:0] pc);
        @(posedge clk);
        #1;
        rst_pc    = pc;
        gnt_en    = 1'b0;
        lat       = 1;
        stall     = 1'b0;
        trap      = 1'b0;
        br_taken  = 1'b0;
        jmp_taken = 1'b0;
        reset_n   = 1'b0;
        @(negedge clk);
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", if_valid, 1'b0);
        chk1("rst_flush", flush_ifid, 1'b0);
        chk1("rst_upd_n", pc_update_n, 1'b1);
        chk("rst_insn", if_insn, 32'h0);
        chk("rst_addr", imem_addr, pc);
        chk("rst_if_pc", if_pc, pc);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic grants(input int n);
        int got = 0;
        int t = 0;
        gnt_en = 1'b1;
        while (got < n && t < 100) begin
            @(negedge clk);
            t++;
            if (imem_req && imem_gnt) got++;
        end
        if (got < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL grant_timeout: got %0d grants, want %0d", got, n);
        end
        @(posedge clk);
        #1;
        gnt_en = 1'b0;
    endtask

    task automatic wait_rvalid();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!imem_rvalid && t < 20);
        chk1("rvalid_seen", imem_rvalid, 1'b1);
    endtask

    task automatic end_scn(input string name);
        int t = 0;
        repeat (3) @(negedge clk);
        while ((q_addr.size() + q_pcn.size() + q_del.size()) != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_pending"}, 32'(q_addr.size() + q_pcn.size() + q_del.size()), 32'h0);
        q_addr.delete();
        q_pcn.delete();
        q_del.delete();
    endtask

    initial begin
        // Sequential fetch from 0
        do_reset(32'h0);
        exp_fetch(32'h0);
        exp_fetch(32'h4);
        exp_fetch(32'h8);
        @(negedge clk);
        chk1("boot_req", imem_req, 1'b0);
        grants(3);
        end_scn("seq");

        // Stall across the response, then release
        do_reset(32'h10);
        stall = 1'b1;
        exp_fetch(32'h10);
        grants(1);
        repeat (3) begin
            @(negedge clk);
            chk1("hold_valid", if_valid, 1'b1);
            chk("hold_insn", if_insn, 32'h00500093);
            chk1("hold_upd_n", pc_update_n, 1'b1);
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
        @(negedge clk);
        chk1("hold_release", pc_update_n, 1'b0);
        end_scn("stall");

        // Branch while waiting for a slow response
        do_reset(32'h20);
        lat = 3;
        q_addr.push_back(32'h20);
        q_pcn.push_back(32'h100);
        grants(1);
        br_taken  = 1'b1;
        br_target = 32'h100;
        @(negedge clk);
        chk1("br_flush", flush_ifid, 1'b1);
        chk("br_pc_next", pc_next, 32'h100);
        @(posedge clk);
        #1;
        br_taken = 1'b0;
        lat      = 1;
        wait_rvalid();
        chk1("drain_valid", if_valid, 1'b0);
        chk1("drain_req", imem_req, 1'b0);
        exp_fetch(32'h100);
        grants(1);
        end_scn("branch");

        // Redirect priority while in REQ
        do_reset(32'h40);
        q_pcn.push_back(32'h80);
        q_pcn.push_back(32'h200);
        q_pcn.push_back(32'h300);
        exp_fetch(32'h300);
        @(posedge clk);
        #1;
        trap       = 1'b1;
        br_taken   = 1'b1;
        jmp_taken  = 1'b1;
        trap_vec   = 32'h80;
        br_target  = 32'h200;
        jmp_target = 32'h300;
        @(negedge clk);
        chk("prio_trap", pc_next, 32'h80);
        chk1("prio_flush", flush_ifid, 1'b1);
        @(posedge clk);
        #1;
        trap = 1'b0;
        @(negedge clk);
        chk("prio_br", pc_next, 32'h200);
        @(posedge clk);
        #1;
        br_taken = 1'b0;
        @(negedge clk);
        chk("prio_jmp", pc_next, 32'h300);
        @(posedge clk);
        #1;
        jmp_taken = 1'b0;
        grants(1);
        end_scn("prio");

        // PC wrap
        do_reset(32'hFFFF_FFFC);
        q_addr.push_back(32'hFFFF_FFFC);
        q_pcn.push_back(32'h0);
        q_del.push_back('{pc: 32'hFFFF_FFFC, insn: insn_of(32'hFFFF_FFFC)});
        grants(1);
        end_scn("wrap");

        // Reset while in RESP
        do_reset(32'h60);
        lat = 3;
        q_addr.push_back(32'h60);
        grants(1);
        reset_n = 1'b0;
        #1;
        chk1("mid_rst_req", imem_req, 1'b0);
        chk1("mid_rst_valid", if_valid, 1'b0);
        chk1("mid_rst_flush", flush_ifid, 1'b0);
        chk1("mid_rst_upd_n", pc_update_n, 1'b1);
        chk("mid_rst_insn", if_insn, 32'h0);
        chk("mid_rst_addr", imem_addr, 32'h60);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk1("mid_rst_boot", imem_req, 1'b0);
        @(negedge clk);
        chk1("mid_rst_req1", imem_req, 1'b1);
        chk("mid_rst_addr1", imem_addr, 32'h60);
        end_scn("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
